// File: rtl/load_store_unit.sv
// Load/store unit: one memory transaction at a time between the pipeline and a
// data memory that returns right-aligned read data one cycle after the strobe.
module load_store_unit #(
    parameter int MEM_ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic        mem_read,
    output logic        mem_half,
    output logic        mem_byte,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic        we_p0;
    logic [2:0]  funct3_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic        err_p0;
    logic [31:0] rdata_p1;

    logic        req_fire;
    logic        req_bad;

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    function automatic logic check_err(input logic        we,
                                       input logic [2:0]  f3,
                                       input logic [31:0] addr);
        logic legal;
        logic bad;
        legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
        bad = !legal;
        if (we && f3[2])
            bad = 1'b1;
        if (is_half(f3) && addr[0])
            bad = 1'b1;
        if ((f3 == F3_W) && (addr[1:0] != 2'b00))
            bad = 1'b1;
        if ((addr >> MEM_ADDR_W) != 32'd0)
            bad = 1'b1;
        return bad;
    endfunction

    // Memory selects the half-word with bit 0, so bit 1 moves down into it.
    function automatic logic [31:0] map_addr(input logic [2:0]  f3,
                                             input logic [31:0] addr);
        logic [31:0] mapped;
        mapped = addr;
        if (is_half(f3))
            mapped[1:0] = {1'b0, addr[1]};
        return mapped;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] d,
                                                input logic [2:0]  f3);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] r_s;
        b_s = d[7:0];
        h_s = d[15:0];
        case (f3)
            F3_B:    r_s = b_s;
            F3_H:    r_s = h_s;
            F3_BU:   r_s = {24'd0, d[7:0]};
            F3_HU:   r_s = {16'd0, d[15:0]};
            default: r_s = d;
        endcase
        return r_s;
    endfunction

    assign req_fire = req_valid & req_ready;
    assign req_bad  = check_err(req_we, req_funct3, req_addr);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_half   = 1'b0;
        mem_byte   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_read   = !we_p0;
                mem_write  = we_p0;
                mem_byte   = (funct3_p0[1:0] == 2'b00);
                mem_half   = (funct3_p0[1:0] == 2'b01);
                state_next = we_p0 ? RESP : WAIT;
            end
            WAIT: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_p0;
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: request captured on the handshake edge
    // Stage p1: load data extended as it is sampled out of WAIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_p0     <= 1'b0;
            funct3_p0 <= 3'b000;
            addr_p0   <= 32'd0;
            wdata_p0  <= 32'd0;
            err_p0    <= 1'b0;
            rdata_p1  <= 32'd0;
        end else begin
            if (req_fire) begin
                we_p0     <= req_we;
                funct3_p0 <= req_funct3;
                addr_p0   <= map_addr(req_funct3, req_addr);
                wdata_p0  <= req_wdata;
                err_p0    <= req_bad;
                rdata_p1  <= 32'd0;
            end
            if (state == WAIT)
                rdata_p1 <= extend_load(mem_rdata, funct3_p0);
        end
    end

    assign mem_addr   = addr_p0;
    assign mem_wdata  = wdata_p0;
    assign resp_rdata = rdata_p1;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array reference model predicts every
// cycle's outputs, and directed transactions pin the model with literals.
module tb_load_store_unit;

    localparam int MAW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic        mem_read;
    logic        mem_half;
    logic        mem_byte;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_ADDR_W(MAW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
        .mem_half(mem_half), .mem_byte(mem_byte), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- data memory seen by the DUT ----------------
    logic [31:0] dev_mem [0:63];
    logic [7:0]  ref_mem [0:255];

    function automatic logic [31:0] init_word(input int w);
        return (w == 0) ? 32'hFF5400A4 : (32'hA5C30000 | 32'(w));
    endfunction

    function automatic logic [31:0] dev_merge(input logic [31:0] old, input logic [31:0] a,
                                              input logic [31:0] d, input logic h, input logic b);
        logic [31:0] r;
        r = old;
        if (b) begin
            case (a[1:0])
                2'd0: r[7:0]   = d[7:0];
                2'd1: r[15:8]  = d[7:0];
                2'd2: r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (h) begin
            if (a[0]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] w, input logic [31:0] a,
                                             input logic h, input logic b);
        logic [31:0] r;
        r = w;
        if (b) begin
            case (a[1:0])
                2'd0: r = {24'd0, w[7:0]};
                2'd1: r = {24'd0, w[15:8]};
                2'd2: r = {24'd0, w[23:16]};
                default: r = {24'd0, w[31:24]};
            endcase
        end else if (h) begin
            r = a[0] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
        end
        return r;
    endfunction

    initial begin
        for (int w = 0; w < 64; w++) begin
            dev_mem[w] <= init_word(w);
            ref_mem[8'(4*w)]   <= init_word(w) & 32'hFF;
            ref_mem[8'(4*w+1)] <= (init_word(w) >> 8) & 32'hFF;
            ref_mem[8'(4*w+2)] <= (init_word(w) >> 16) & 32'hFF;
            ref_mem[8'(4*w+3)] <= init_word(w) >> 24;
        end
    end

    always @(posedge clk) begin
        if (mem_write)
            dev_mem[mem_addr[7:2]] <= dev_merge(dev_mem[mem_addr[7:2]], mem_addr, mem_wdata, mem_half, mem_byte);
        if (mem_read)
            mem_rdata <= dev_read(dev_mem[mem_addr[7:2]], mem_addr, mem_half, mem_byte);
    end

    // ---------------- reference model ----------------
    bit          model_ok;
    bit          busy;
    int          k;
    int          m_lat;
    logic        m_we;
    logic        m_err;
    logic [2:0]  m_f3;
    logic [31:0] m_rdata;
    logic [31:0] last_maddr;
    logic [31:0] last_wdata;
    logic        cur_err;
    logic [7:0]  i0, i1, i2, i3;

    function automatic logic model_err(input logic we, input logic [2:0] f, input logic [31:0] a);
        logic legal;
        legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
        return !legal || (we && f >= 3'd4) || ((f == 3'd1 || f == 3'd5) && a[0]) ||
               (f == 3'd2 && a[1:0] != 2'd0) || (a >= 32'(1 << MAW));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [7:0] a0,
                                               input logic [7:0] a1, input logic [7:0] a2,
                                               input logic [7:0] a3);
        case (f)
            3'd0: return {{24{ref_mem[a0][7]}}, ref_mem[a0]};
            3'd4: return {24'd0, ref_mem[a0]};
            3'd1: return {{16{ref_mem[a1][7]}}, ref_mem[a1], ref_mem[a0]};
            3'd5: return {16'd0, ref_mem[a1], ref_mem[a0]};
            default: return {ref_mem[a3], ref_mem[a2], ref_mem[a1], ref_mem[a0]};
        endcase
    endfunction

    assign cur_err = model_err(req_we, req_funct3, req_addr);
    assign i0 = req_addr[7:0];
    assign i1 = i0 + 8'd1;
    assign i2 = i0 + 8'd2;
    assign i3 = i0 + 8'd3;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_ok   <= 1'b1;
            busy       <= 1'b0;
            k          <= 0;
            last_maddr <= 32'd0;
            last_wdata <= 32'd0;
        end else if (busy) begin
            k <= k + 1;
            if (k >= m_lat && resp_ready)
                busy <= 1'b0;
        end else if (req_valid) begin
            busy    <= 1'b1;
            k       <= 1;
            m_we    <= req_we;
            m_f3    <= req_funct3;
            m_err   <= cur_err;
            m_lat   <= cur_err ? 1 : (req_we ? 2 : 3);
            m_rdata <= (cur_err || req_we) ? 32'd0 : model_load(req_funct3, i0, i1, i2, i3);
            last_maddr <= (req_funct3 == 3'd1 || req_funct3 == 3'd5)
                          ? ((req_addr & 32'hFFFFFFFC) | (req_addr[1] ? 32'd1 : 32'd0))
                          : req_addr;
            last_wdata <= req_wdata;
            if (req_we && !cur_err) begin
                ref_mem[i0] <= req_wdata[7:0];
                if (req_funct3 != 3'd0) ref_mem[i1] <= req_wdata[15:8];
                if (req_funct3 == 3'd2) begin
                    ref_mem[i2] <= req_wdata[23:16];
                    ref_mem[i3] <= req_wdata[31:24];
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            logic in_resp, in_acc;
            in_resp = busy && (k >= m_lat);
            in_acc  = busy && (k == 1) && !m_err;
            chk1("req_ready", req_ready, !busy);
            chk1("resp_valid", resp_valid, in_resp);
            chk1("resp_err", resp_err, in_resp ? m_err : 1'b0);
            if (in_resp)
                chk32("resp_rdata", resp_rdata, m_rdata);
            chk1("mem_read", mem_read, in_acc && !m_we);
            chk1("mem_write", mem_write, in_acc && m_we);
            chk1("mem_byte", mem_byte, in_acc && (m_f3 == 3'd0 || m_f3 == 3'd4));
            chk1("mem_half", mem_half, in_acc && (m_f3 == 3'd1 || m_f3 == 3'd5));
            chk32("mem_addr", mem_addr, last_maddr);
            chk32("mem_wdata", mem_wdata, last_wdata);
        end
    end

    int rd_pulses = 0;
    int wr_pulses = 0;
    always @(negedge clk) begin
        if (mem_read)  rd_pulses <= rd_pulses + 1;
        if (mem_write) wr_pulses <= wr_pulses + 1;
    end

    // ---------------- directed transactions ----------------
    logic [31:0] acc_addr;
    logic        acc_half, acc_byte, acc_read, acc_write;
    int          rd_delta, wr_delta;

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int n, cyc, rd0, wr0;
        logic got;
        logic [31:0] first;
        @(negedge clk);
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        resp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("handshake_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_we = ~we; req_funct3 = 3'b010; req_addr = 32'h00000010; req_wdata = 32'hDEADBEEF;
        cyc = 1;
        got = 1'b0;
        while (cyc <= 8) begin
            @(negedge clk);
            if (cyc == 1) begin
                acc_addr = mem_addr; acc_half = mem_half; acc_byte = mem_byte;
                acc_read = mem_read; acc_write = mem_write;
            end
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            cyc++;
        end
        chk1("resp_seen", got, 1'b1);
        chk32("latency", 32'(cyc), 32'(exp_lat));
        chk32("lit_rdata", resp_rdata, exp_rdata);
        chk1("lit_err", resp_err, exp_err);
        first = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk1("hold_valid", resp_valid, 1'b1);
            chk32("hold_rdata", resp_rdata, first);
            chk1("hold_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(negedge clk);
        chk1("idle_after_ack", req_ready, 1'b1);
        chk1("valid_after_ack", resp_valid, 1'b0);
        resp_ready = 1'b0;
        rd_delta = rd_pulses - rd0;
        wr_delta = wr_pulses - wr0;
    endtask

    task automatic chk_reset_outputs();
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_err", resp_err, 1'b0);
        chk32("rst_resp_rdata", resp_rdata, 32'd0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk32("rst_mem_wdata", mem_wdata, 32'd0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk1("rst_mem_half", mem_half, 1'b0);
        chk1("rst_mem_byte", mem_byte, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("ready_after_reset", req_ready, 1'b1);

        do_req(1'b0, 3'b000, 32'h00, 32'd0, 0, 32'hFFFFFFA4, 1'b0, 3);
        chk1("lb_byte", acc_byte, 1'b1);
        chk1("lb_read", acc_read, 1'b1);
        chk1("lb_half", acc_half, 1'b0);
        do_req(1'b0, 3'b100, 32'h00, 32'd0, 0, 32'h000000A4, 1'b0, 3);
        chk1("lbu_byte", acc_byte, 1'b1);
        do_req(1'b0, 3'b001, 32'h02, 32'd0, 0, 32'hFFFFFF54, 1'b0, 3);
        chk32("lh_addr", acc_addr, 32'h00000001);
        chk1("lh_half", acc_half, 1'b1);
        do_req(1'b0, 3'b101, 32'h02, 32'd0, 0, 32'h0000FF54, 1'b0, 3);

        do_req(1'b0, 3'b010, 32'h01, 32'd0, 0, 32'd0, 1'b1, 1);
        chk32("lw_mis_reads", 32'(rd_delta), 32'd0);
        do_req(1'b0, 3'b010, 32'h100, 32'd0, 0, 32'd0, 1'b1, 1);
        chk32("lw_oor_reads", 32'(rd_delta), 32'd0);

        do_req(1'b1, 3'b010, 32'h04, 32'h12345678, 0, 32'd0, 1'b0, 2);
        chk32("sw_pulses", 32'(wr_delta), 32'd1);
        chk1("sw_write", acc_write, 1'b1);
        do_req(1'b0, 3'b010, 32'h04, 32'd0, 0, 32'h12345678, 1'b0, 3);
        do_req(1'b1, 3'b000, 32'h05, 32'h000000AB, 0, 32'd0, 1'b0, 2);
        do_req(1'b0, 3'b010, 32'h04, 32'd0, 0, 32'h1234AB78, 1'b0, 3);
        do_req(1'b0, 3'b000, 32'h05, 32'd0, 0, 32'hFFFFFFAB, 1'b0, 3);
        do_req(1'b1, 3'b001, 32'h06, 32'h00008001, 0, 32'd0, 1'b0, 2);
        chk32("sh_addr", acc_addr, 32'h00000005);
        do_req(1'b0, 3'b010, 32'h04, 32'd0, 0, 32'h8001AB78, 1'b0, 3);
        do_req(1'b0, 3'b001, 32'h06, 32'd0, 0, 32'hFFFF8001, 1'b0, 3);

        do_req(1'b1, 3'b100, 32'h08, 32'h11, 0, 32'd0, 1'b1, 1);
        chk32("sbu_writes", 32'(wr_delta), 32'd0);
        do_req(1'b0, 3'b011, 32'h08, 32'd0, 0, 32'd0, 1'b1, 1);
        do_req(1'b1, 3'b011, 32'h08, 32'd0, 0, 32'd0, 1'b1, 1);
        do_req(1'b0, 3'b110, 32'h08, 32'd0, 0, 32'd0, 1'b1, 1);
        do_req(1'b0, 3'b001, 32'h03, 32'd0, 0, 32'd0, 1'b1, 1);
        do_req(1'b1, 3'b010, 32'h02, 32'h55, 0, 32'd0, 1'b1, 1);
        do_req(1'b0, 3'b010, 32'hFC, 32'd0, 0, 32'hA5C3003F, 1'b0, 3);

        do_req(1'b0, 3'b010, 32'h00, 32'd0, 5, 32'hFF5400A4, 1'b0, 3);

        // reset while the load sits in WAIT
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00; req_wdata = 32'h0;
        resp_ready = 1'b1;
        chk1("wait_rst_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk1("wait_rst_access", mem_read, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk1("no_stale_resp", resp_valid, 1'b0);
            chk1("ready_post_rst", req_ready, 1'b1);
        end
        resp_ready = 1'b0;

        do_req(1'b0, 3'b010, 32'h04, 32'd0, 0, 32'h8001AB78, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_ADDR_W, default 8: number of byte-address bits the data memory decodes.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  pipeline consumes the response.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned, out-of-range, or illegal-width request.
REQ-014 SHALL have ports mem_addr (output, 32), mem_write (output, 1), mem_read (output, 1), mem_half (output, 1), mem_byte (output, 1), mem_wdata (output, 32), and mem_rdata (input, 32), all toward the data memory.

Function
REQ-015 SHALL implement states IDLE, ACCESS, WAIT, and RESP; req_ready=1 only in IDLE.
REQ-016 SHALL latch we/funct3/addr/wdata on the handshake edge (req_valid & req_ready) and check the request.
REQ-017 SHALL treat the request as an error if any of the following holds: funct3 is outside {000, 001, 010, 100, 101}; funct3=011 with req_we=1; a half access with addr[0]=1; a word access with addr[1:0]≠00; addr[31:MEM_ADDR_W]≠0; a store with funct3=1xx.
REQ-018 SHALL go IDLE→RESP on an error request, with resp_err=1, resp_rdata=0, and no memory strobe ever asserted.
REQ-019 SHALL go IDLE→ACCESS on a valid request.
REQ-020 SHALL in ACCESS assert exactly one of mem_read or mem_write for exactly one cycle, with mem_byte = width B/BU, mem_half = width H/HU, and mem_wdata = latched wdata.
REQ-021 SHALL drive mem_addr = latched addr, except for half accesses, where mem_addr[1:0] = {0, addr[1]} (memory selects the half by bit 0).
REQ-022 SHALL go ACCESS→RESP for stores and ACCESS→WAIT for loads.
REQ-023 SHALL in WAIT sample mem_rdata (valid one cycle after the read strobe) and go to RESP.
REQ-024 SHALL extend the sampled data in RESP as follows: B sign-extends bit 7; BU zero-extends [7:0]; H sign-extends bit 15; HU zero-extends [15:0]; W passes all 32 bits.
REQ-025 SHALL hold resp_valid=1 in RESP, with resp_rdata and resp_err stable, until resp_ready=1; then go RESP→IDLE.
REQ-026 SHALL NOT accept a new request in the RESP→IDLE cycle; at most one transaction is in flight.
REQ-027 SHALL set latency from handshake edge to first resp_valid cycle: load 3 cycles, store 2, error 1.
REQ-028 SHALL drive mem_read, mem_write, mem_half, and mem_byte to 0 outside ACCESS, and keep mem_addr and mem_wdata equal to the last latched values.
REQ-029 SHALL ignore req_valid while req_ready=0; no request is lost or duplicated.

Reset
REQ-030 SHALL while rst_n=0 at a rising edge enter IDLE with resp_valid, resp_err, mem_read, mem_write, mem_half, and mem_byte all 0 and resp_rdata, mem_addr, and mem_wdata all 0x00000000.
REQ-031 SHALL on reset mid-transaction (ACCESS, WAIT, or RESP) abort; the pending response is discarded and never presented.
REQ-032 SHALL have req_ready=1 on the first cycle after rst_n returns high.

Verification
REQ-033 SHALL cover: memory word 0 = 0xFF5400A4; LB addr 0x00 → resp_rdata 0xFFFFFFA4; LBU addr 0x00 → 0x000000A4; mem_byte=1 during ACCESS.
REQ-034 SHALL cover: LH addr 0x02 → mem_addr 0x00000001, mem_half=1, resp_rdata 0xFFFFFF54; LHU addr 0x02 → 0x0000FF54.
REQ-035 SHALL cover: LW addr 0x01 → resp_err=1 one cycle after the handshake, mem_read never asserted; LW addr 0x100 (MEM_ADDR_W=8) → resp_err=1.
REQ-036 SHALL cover: SW addr 0x04 with data 0x12345678, then LW addr 0x04 → mem_write pulse of exactly one cycle; load returns 0x12345678.
REQ-037 SHALL cover: resp_ready held 0 for 5 cycles → resp_valid and resp_rdata stable and req_ready=0 throughout; IDLE entered the cycle after resp_ready=1.
REQ-038 SHALL cover: rst_n=0 asserted in WAIT → next cycle IDLE with all outputs at reset values and no resp_valid pulse.
